// File: rtl/sdram_read_pkg.sv
// sdram_read_pkg
// Shared definitions for the SDRAM frame reader: FSM state encoding,
// default burst/FIFO geometry and the widths of the Avalon burstcount
// and frame-size fields.
// No ports (package only).
package sdram_read_pkg;

    localparam int DEF_BURST_LEN  = 32;
    localparam int DEF_FIFO_DEPTH = 256;
    localparam int DEF_ADDR_W     = 29;

    // Avalon burstcount field width; a burst never exceeds 128 words.
    localparam int BURSTCOUNT_W   = 8;
    localparam int FRAME_W        = 24;
    localparam int DATA_W         = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/sdram_read_fifo.sv
// sdram_read_fifo
// Single-clock first-word-fall-through FIFO for read data coming back from
// SDRAM. The head word is visible on rd_data whenever empty is low, so a
// pop simply advances to the next entry.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   wr_en, wr_data  push one word (ignored when full)
//   rd_en           pop the head word (ignored when empty)
//   rd_data         head word, zero while empty
//   usedw           number of stored words (0..DEPTH)
//   full, empty     occupancy flags
module sdram_read_fifo
    import sdram_read_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]  usedw,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage is left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign usedw   = count;
    // Zero the head while empty so the output reads 0 out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sdram_read_frame.sv
// sdram_read_frame
// Avalon-MM burst-read master that fetches one video frame from the SDRAM
// double buffer (always the half the writer is not filling) and streams it
// out as 64-bit words. A burst is only requested when the local FIFO is
// guaranteed to have room for every word of that burst, so read data can
// never be lost.
// Ports:
//   clk_100, reset_n           clock and asynchronous active-low reset
//   start_frame                one-cycle request to read a frame
//   wr_buf_sel                 buffer the writer is filling (0=buf_1, 1=buf_2)
//   reg_addr_buf_1/2           buffer base word addresses
//   frame_words                words in the frame, sampled at start_frame
//   avl_*                      Avalon-MM burst read master interface
//   out_data/out_valid/ready   streamed frame words (valid/ready handshake)
//   end_frame                  pulse after the last word is accepted
//   busy                       frame in progress
//   overrun                    sticky: start_frame seen while busy
module sdram_read_frame
    import sdram_read_pkg::*;
#(
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                    clk_100,
    input  logic                    reset_n,
    input  logic                    start_frame,
    input  logic                    wr_buf_sel,
    input  logic [31:0]             reg_addr_buf_1,
    input  logic [31:0]             reg_addr_buf_2,
    input  logic [FRAME_W-1:0]      frame_words,
    output logic [ADDR_W-1:0]       avl_address,
    output logic                    avl_read,
    output logic [BURSTCOUNT_W-1:0] avl_burstcount,
    input  logic                    avl_waitrequest,
    input  logic [DATA_W-1:0]       avl_readdata,
    input  logic                    avl_readdatavalid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    end_frame,
    output logic                    busy,
    output logic                    overrun
);

    // Wide enough to hold FIFO_DEPTH itself, for both occupancy and
    // the count of words requested but not yet returned.
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    state_t                  state_next;

    logic [ADDR_W-1:0]       addr;
    logic [FRAME_W-1:0]      remaining;
    logic [FRAME_W-1:0]      out_left;
    logic [CNT_W-1:0]        outstanding;
    logic [BURSTCOUNT_W-1:0] len;
    logic [ADDR_W-1:0]       base_sel;

    logic                    room_ok;
    logic                    start_go;
    logic                    start_zero;
    logic                    req_accept;
    logic                    beat_accept;
    logic                    pop;
    logic                    last_pop;

    logic [CNT_W-1:0]        fifo_usedw;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_head;

    // Only the low ADDR_W bits of the base registers address SDRAM words.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{reg_addr_buf_1[31:ADDR_W], reg_addr_buf_2[31:ADDR_W]};

    // The reader takes the half the writer is not currently filling.
    assign base_sel = wr_buf_sel ? reg_addr_buf_1[ADDR_W-1:0]
                                 : reg_addr_buf_2[ADDR_W-1:0];

    assign start_go    = start_frame && (state == S_IDLE) && (frame_words != '0);
    assign start_zero  = start_frame && (state == S_IDLE) && (frame_words == '0);
    assign req_accept  = (state == S_REQ) && avl_read && !avl_waitrequest;
    // Beats returning while idle belong to a frame killed by reset.
    assign beat_accept = avl_readdatavalid && (state != S_IDLE);
    assign pop         = out_valid && out_ready;
    assign last_pop    = pop && busy && (out_left == FRAME_W'(1));

    // Next burst is BURST_LEN words, or whatever is left of the frame.
    always_comb begin
        len = BURSTCOUNT_W'(BURST_LEN);
        if (remaining < FRAME_W'(BURST_LEN)) begin
            len = remaining[BURSTCOUNT_W-1:0];
        end
    end

    // Words already stored plus words still in flight plus this burst must
    // fit, otherwise returning data could overflow the FIFO.
    assign room_ok = (32'(fifo_usedw) + 32'(outstanding) + 32'(len)) <= 32'(FIFO_DEPTH);

    // FSM state register.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The final pop ends the frame from any active state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_go) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (remaining == '0) begin
                    state_next = S_DRAIN;
                end else if (room_ok) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (req_accept) begin
                    state_next = S_CHECK;
                end
            end
            S_DRAIN: begin
                state_next = S_DRAIN;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (last_pop) begin
            state_next = S_IDLE;
        end
    end

    // Address and word counters. The address register drives the bus
    // directly and only moves on acceptance, so it is stable while stalled;
    // it wraps modulo 2^ADDR_W.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
            out_left  <= '0;
        end else begin
            if (start_go) begin
                addr      <= base_sel;
                remaining <= frame_words;
            end else if (req_accept) begin
                addr      <= addr + ADDR_W'(avl_burstcount);
                remaining <= remaining - FRAME_W'(avl_burstcount);
            end

            if (start_go) begin
                out_left <= frame_words;
            end else if (pop && (out_left != '0)) begin
                out_left <= out_left - FRAME_W'(1);
            end
        end
    end

    // In-flight word count: an accepted burst adds its length, each
    // returning beat removes one; both can happen in the same cycle.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding
                         + (req_accept ? CNT_W'(avl_burstcount) : CNT_W'(0))
                         - CNT_W'(beat_accept);
        end
    end

    // Avalon request registers: loaded on entry to REQ, held through
    // waitrequest, and read dropped right after acceptance.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            avl_read       <= 1'b0;
            avl_burstcount <= '0;
        end else begin
            if ((state == S_CHECK) && (state_next == S_REQ)) begin
                avl_read       <= 1'b1;
                avl_burstcount <= len;
            end else if (req_accept) begin
                avl_read       <= 1'b0;
            end
        end
    end

    // Frame status flags. A zero-length frame only produces end_frame.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            end_frame <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (start_go) begin
                busy <= 1'b1;
            end else if (last_pop) begin
                busy <= 1'b0;
            end
            end_frame <= last_pop || start_zero;
            if (start_frame && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    assign avl_address = addr;

    sdram_read_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_100),
        .rst_n   (reset_n),
        .wr_en   (beat_accept),
        .wr_data (avl_readdata),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .usedw   (fifo_usedw),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;

    // The room check before every burst makes a write into a full FIFO
    // impossible; if it ever happens the flow control is broken.
    fifo_no_overflow: assert property (
        @(posedge clk_100) disable iff (!reset_n) !(beat_accept && fifo_full)
    );

endmodule

// File: tb/tb_sdram_read_frame.sv
// tb_sdram_read_frame
// Directed bench for sdram_read_frame: a zero-latency Avalon slave model
// whose memory word encodes its own address, a monitor logging bursts,
// output pops and end_frame pulses, and one task per scenario.
module tb_sdram_read_frame;

    logic        clk_100 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_frame = 1'b0;
    logic        wr_buf_sel = 1'b0;
    logic [31:0] reg_addr_buf_1 = 32'h0020_0000;
    logic [31:0] reg_addr_buf_2 = 32'h0010_0000;
    logic [23:0] frame_words = '0;
    logic [28:0] avl_address;
    logic        avl_read;
    logic [7:0]  avl_burstcount;
    logic        avl_waitrequest = 1'b0;
    logic [63:0] avl_readdata = '0;
    logic        avl_readdatavalid = 1'b0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        end_frame;
    logic        busy;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;

    int          cyc = 0;
    int          start_cyc = 0;
    logic [28:0] req_addr_q[$];
    logic [7:0]  req_cnt_q[$];
    logic [28:0] beat_q[$];
    logic [63:0] pop_q[$];
    int          pop_cyc_q[$];
    int          end_cyc_q[$];
    int          rise_cyc_q[$];
    logic        read_prev = 1'b0;

    int          stall_left = 0;
    int          stall_seen = 0;
    bit          stall_unstable = 1'b0;
    logic [28:0] snap_addr = '0;
    logic [7:0]  snap_cnt = '0;

    sdram_read_frame dut (
        .clk_100           (clk_100),
        .reset_n           (reset_n),
        .start_frame       (start_frame),
        .wr_buf_sel        (wr_buf_sel),
        .reg_addr_buf_1    (reg_addr_buf_1),
        .reg_addr_buf_2    (reg_addr_buf_2),
        .frame_words       (frame_words),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_burstcount    (avl_burstcount),
        .avl_waitrequest   (avl_waitrequest),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .end_frame         (end_frame),
        .busy              (busy),
        .overrun           (overrun)
    );

    always #5 clk_100 = ~clk_100;

    always @(posedge clk_100) cyc <= cyc + 1;

    // Memory contents: a tag plus the word address, so order and
    // addressing errors both show up as data errors.
    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {16'hC0DE, 19'h0, a};
    endfunction

    function automatic logic [63:0] frame_word(input logic [28:0] base, input int k);
        logic [28:0] a;
        a = base + 29'(k);
        return mem_word(a);
    endfunction

    // Avalon slave: one beat per cycle from the pending queue, requests
    // appended after the beat so data starts the cycle after acceptance.
    initial begin
        forever begin
            @(negedge clk_100);
            #1;
            if (beat_q.size() > 0) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = mem_word(beat_q.pop_front());
            end else begin
                avl_readdatavalid = 1'b0;
                avl_readdata      = '0;
            end
            if (avl_read && stall_left > 0) begin
                avl_waitrequest = 1'b1;
                stall_left--;
                stall_seen++;
                if (stall_seen == 1) begin
                    snap_addr = avl_address;
                    snap_cnt  = avl_burstcount;
                end else if (avl_address !== snap_addr || avl_burstcount !== snap_cnt) begin
                    stall_unstable = 1'b1;
                end
            end else begin
                if (stall_seen > 0 && stall_left > 0) stall_unstable = 1'b1;
                avl_waitrequest = 1'b0;
                if (avl_read) begin
                    req_addr_q.push_back(avl_address);
                    req_cnt_q.push_back(avl_burstcount);
                    for (int i = 0; i < int'(avl_burstcount); i++)
                        beat_q.push_back(avl_address + 29'(i));
                end
            end
        end
    end

    // Monitor: logs pops, end_frame pulses and avl_read rising edges.
    initial begin
        forever begin
            @(negedge clk_100);
            #2;
            if (out_valid && out_ready) begin
                pop_q.push_back(out_data);
                pop_cyc_q.push_back(cyc);
            end
            if (end_frame) end_cyc_q.push_back(cyc);
            if (avl_read && !read_prev) rise_cyc_q.push_back(cyc);
            read_prev = avl_read;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_logs();
        @(negedge clk_100);
        req_addr_q.delete();
        req_cnt_q.delete();
        pop_q.delete();
        pop_cyc_q.delete();
        end_cyc_q.delete();
        rise_cyc_q.delete();
    endtask

    task automatic pulse_start(input logic [23:0] fw, input logic sel);
        @(negedge clk_100);
        frame_words = fw;
        wr_buf_sel  = sel;
        start_frame = 1'b1;
        start_cyc   = cyc;
        @(negedge clk_100);
        start_frame = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100);
            if (end_cyc_q.size() > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (5) @(negedge clk_100);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_100);
        vectors++;
        if ({avl_read, avl_address, avl_burstcount} !== 38'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_avl: got read=%b addr=%h cnt=%h, required all 0", avl_read, avl_address, avl_burstcount);
        end
        vectors++;
        if ({out_valid, out_data} !== 65'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_out: got valid=%b data=%h, required 0", out_valid, out_data);
        end
        vectors++;
        if ({end_frame, busy, overrun} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got end/busy/overrun=%b, required 000", {end_frame, busy, overrun});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk_100);
    endtask

    task automatic test_zero_frame();
        clear_logs();
        pulse_start(24'd0, 1'b0);
        vectors++;
        if ({end_frame, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL zero_frame_pulse: got end/busy=%b, required 10", {end_frame, busy});
        end
        @(negedge clk_100);
        vectors++;
        if ({end_frame, busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL zero_frame_after: got end/busy=%b, required 00", {end_frame, busy});
        end
        repeat (4) @(negedge clk_100);
        vectors++;
        if (req_addr_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL zero_frame_reqs: got %0d bursts, required 0", req_addr_q.size());
        end
    endtask

    task automatic test_basic_frame();
        bit to;
        clear_logs();
        out_ready = 1'b1;
        pulse_start(24'd96, 1'b0);
        wait_end(2000, to);
        vectors++;
        if (to !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_timeout: got no end_frame, required one");
        end
        vectors++;
        if (rise_cyc_q.size() == 0 || rise_cyc_q[0] != start_cyc + 2) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: got first read at %0d, required %0d", rise_cyc_q.size() ? rise_cyc_q[0] : -1, start_cyc + 2);
        end
        vectors++;
        if (req_addr_q.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL basic_bursts: got %0d bursts, required 3", req_addr_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (req_addr_q[k] !== 29'h0010_0000 + 29'(32 * k) || req_cnt_q[k] !== 8'd32) begin
                    miscompares++;
                    $display("[TB] FAIL basic_burst%0d: got addr=%h cnt=%0d, required addr=%h cnt=32", k, req_addr_q[k], req_cnt_q[k], 29'h0010_0000 + 29'(32 * k));
                end
            end
        end
        vectors++;
        if (pop_q.size() != 96) begin
            miscompares++;
            $display("[TB] FAIL basic_count: got %0d words, required 96", pop_q.size());
        end
        for (int k = 0; k < pop_q.size(); k++) begin
            vectors++;
            if (pop_q[k] !== frame_word(29'h0010_0000, k)) begin
                miscompares++;
                $display("[TB] FAIL basic_word%0d: got %h, required %h", k, pop_q[k], frame_word(29'h0010_0000, k));
                break;
            end
        end
        vectors++;
        if (end_cyc_q.size() != 1 || pop_cyc_q.size() == 0 || end_cyc_q[0] != pop_cyc_q[pop_cyc_q.size() - 1] + 1) begin
            miscompares++;
            $display("[TB] FAIL basic_end_frame: got %0d pulses, required exactly 1 one cycle after last pop", end_cyc_q.size());
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_partial_frame();
        bit to;
        logic [7:0] exp_cnt [3] = '{8'd32, 8'd32, 8'd6};
        clear_logs();
        reg_addr_buf_1 = 32'h0030_0000;
        pulse_start(24'd70, 1'b1);
        wait_end(2000, to);
        vectors++;
        if (to !== 1'b0 || req_addr_q.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL partial_bursts: got %0d bursts (timeout=%b), required 3", req_addr_q.size(), to);
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (req_addr_q[k] !== 29'h0030_0000 + 29'(32 * k) || req_cnt_q[k] !== exp_cnt[k]) begin
                    miscompares++;
                    $display("[TB] FAIL partial_burst%0d: got addr=%h cnt=%0d, required addr=%h cnt=%0d", k, req_addr_q[k], req_cnt_q[k], 29'h0030_0000 + 29'(32 * k), exp_cnt[k]);
                end
            end
        end
        vectors++;
        if (pop_q.size() != 70) begin
            miscompares++;
            $display("[TB] FAIL partial_count: got %0d words, required 70", pop_q.size());
        end
        for (int k = 0; k < pop_q.size(); k++) begin
            vectors++;
            if (pop_q[k] !== frame_word(29'h0030_0000, k)) begin
                miscompares++;
                $display("[TB] FAIL partial_word%0d: got %h, required %h", k, pop_q[k], frame_word(29'h0030_0000, k));
                break;
            end
        end
    endtask

    task automatic test_addr_wrap();
        bit to;
        clear_logs();
        reg_addr_buf_2 = 32'hFFFF_FFF0;
        pulse_start(24'd64, 1'b0);
        wait_end(2000, to);
        vectors++;
        if (to !== 1'b0 || req_addr_q.size() != 2 || req_addr_q[0] !== 29'h1FFF_FFF0 || req_addr_q[1] !== 29'h0000_0010) begin
            miscompares++;
            $display("[TB] FAIL wrap_addrs: got %0d bursts first=%h second=%h, required 1ffffff0 then 00000010", req_addr_q.size(), req_addr_q.size() > 0 ? req_addr_q[0] : 29'h0, req_addr_q.size() > 1 ? req_addr_q[1] : 29'h0);
        end
        vectors++;
        if (pop_q.size() != 64) begin
            miscompares++;
            $display("[TB] FAIL wrap_count: got %0d words, required 64", pop_q.size());
        end
        for (int k = 0; k < pop_q.size(); k++) begin
            vectors++;
            if (pop_q[k] !== frame_word(29'h1FFF_FFF0, k)) begin
                miscompares++;
                $display("[TB] FAIL wrap_word%0d: got %h, required %h", k, pop_q[k], frame_word(29'h1FFF_FFF0, k));
                break;
            end
        end
        reg_addr_buf_2 = 32'h0010_0000;
    endtask

    task automatic test_waitrequest();
        bit to;
        clear_logs();
        stall_seen     = 0;
        stall_unstable = 1'b0;
        stall_left     = 5;
        pulse_start(24'd32, 1'b0);
        wait_end(2000, to);
        vectors++;
        if (stall_seen != 5 || stall_unstable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wait_stable: got %0d stall cycles unstable=%b, required 5 stable", stall_seen, stall_unstable);
        end
        vectors++;
        if (to !== 1'b0 || req_addr_q.size() != 1 || req_addr_q[0] !== 29'h0010_0000 || req_cnt_q[0] !== 8'd32) begin
            miscompares++;
            $display("[TB] FAIL wait_bursts: got %0d bursts, required 1 at 00100000 of 32", req_addr_q.size());
        end
        vectors++;
        if (pop_q.size() != 32 || end_cyc_q.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL wait_words: got %0d words %0d end pulses, required 32 and 1", pop_q.size(), end_cyc_q.size());
        end
        stall_seen = 0;
        stall_left = 0;
    endtask

    task automatic test_backpressure();
        bit to;
        clear_logs();
        out_ready = 1'b0;
        pulse_start(24'd1024, 1'b0);
        repeat (400) @(negedge clk_100);
        vectors++;
        if (req_addr_q.size() != 8) begin
            miscompares++;
            $display("[TB] FAIL bp_bursts_held: got %0d bursts, required 8", req_addr_q.size());
        end
        vectors++;
        if ({out_valid, busy} !== 2'b11 || pop_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_state: got valid/busy=%b pops=%0d, required 11 and 0", {out_valid, busy}, pop_q.size());
        end
        out_ready = 1'b1;
        wait_end(4000, to);
        vectors++;
        if (to !== 1'b0 || req_addr_q.size() != 32 || end_cyc_q.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL bp_complete: got %0d bursts %0d end pulses (timeout=%b), required 32 and 1", req_addr_q.size(), end_cyc_q.size(), to);
        end
        vectors++;
        if (pop_q.size() != 1024) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d words, required 1024", pop_q.size());
        end
        for (int k = 0; k < pop_q.size(); k++) begin
            vectors++;
            if (pop_q[k] !== frame_word(29'h0010_0000, k)) begin
                miscompares++;
                $display("[TB] FAIL bp_word%0d: got %h, required %h", k, pop_q[k], frame_word(29'h0010_0000, k));
                break;
            end
        end
    endtask

    task automatic test_overrun();
        bit to;
        clear_logs();
        pulse_start(24'd96, 1'b0);
        repeat (8) @(negedge clk_100);
        pulse_start(24'd5, 1'b1);
        @(negedge clk_100);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overrun_flag: got %b, required 1", overrun);
        end
        wait_end(2000, to);
        vectors++;
        if (to !== 1'b0 || req_addr_q.size() != 3 || req_addr_q[2] !== 29'h0010_0040) begin
            miscompares++;
            $display("[TB] FAIL overrun_bursts: got %0d bursts, required 3 ending at 00100040", req_addr_q.size());
        end
        vectors++;
        if (pop_q.size() != 96 || end_cyc_q.size() != 1 || overrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overrun_frame: got %0d words %0d ends overrun=%b, required 96 1 1", pop_q.size(), end_cyc_q.size(), overrun);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        bit hit;
        clear_logs();
        pulse_start(24'd64, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_100);
            if (req_addr_q.size() >= 2 && beat_q.size() <= 10) begin
                hit = 1'b1;
                break;
            end
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (hit !== 1'b1 || {avl_read, avl_address, avl_burstcount, out_valid, end_frame, busy, overrun} !== 42'h0 || out_data !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got read=%b addr=%h valid=%b busy=%b overrun=%b (hit=%b), required all 0", avl_read, avl_address, out_valid, busy, overrun, hit);
        end
        repeat (2) @(negedge clk_100);
        reset_n = 1'b1;
        pop_q.delete();
        end_cyc_q.delete();
        for (int i = 0; i < 100 && beat_q.size() > 0; i++) @(negedge clk_100);
        repeat (3) @(negedge clk_100);
        vectors++;
        if (pop_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0 || end_cyc_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_late_beats: got %0d words valid=%b busy=%b, required 0 0 0", pop_q.size(), out_valid, busy);
        end
        clear_logs();
        pulse_start(24'd32, 1'b0);
        wait_end(2000, to);
        vectors++;
        if (to !== 1'b0 || req_addr_q.size() != 1 || pop_q.size() != 32 || end_cyc_q.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL midreset_new_frame: got %0d bursts %0d words %0d ends, required 1 32 1", req_addr_q.size(), pop_q.size(), end_cyc_q.size());
        end
        for (int k = 0; k < pop_q.size(); k++) begin
            vectors++;
            if (pop_q[k] !== frame_word(29'h0010_0000, k)) begin
                miscompares++;
                $display("[TB] FAIL midreset_word%0d: got %h, required %h", k, pop_q[k], frame_word(29'h0010_0000, k));
                break;
            end
        end
    endtask

    initial begin
        $display("[TB] sdram_read_frame directed tests");
        test_reset();
        test_zero_frame();
        test_basic_frame();
        test_partial_frame();
        test_addr_wrap();
        test_waitrequest();
        test_backpressure();
        test_overrun();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
